// File: rtl/link_stack_branch_unit_if.sv
// Port bundle for link_stack_branch_unit: branch request, flags, next-PC result and stack status.
// LINK_STACK_ERR_EN adds the sticky overflow/underflow flags and their clear.
interface link_stack_branch_unit_if #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          op_valid;
    logic [2:0]    branch_op;
    logic [1:0]    cond_sel;
    logic          zero;
    logic          negative;
    logic [AW-1:0] ea;
    logic [AW-1:0] pc_inc;
    logic          flush;
    logic [AW-1:0] next_pc;
    logic          taken;
    logic [AW-1:0] stack_top;
    logic [CW-1:0] stack_count;
    logic          stack_empty;
    logic          stack_full;
`ifdef LINK_STACK_ERR_EN
    logic          stack_overflow;
    logic          stack_underflow;
    logic          err_clear;
`endif

    modport master (
        output op_valid, branch_op, cond_sel, zero, negative, ea, pc_inc, flush,
        input  next_pc, taken, stack_top, stack_count, stack_empty, stack_full
`ifdef LINK_STACK_ERR_EN
        , output err_clear
        , input  stack_overflow, stack_underflow
`endif
    );

    modport slave (
        input  op_valid, branch_op, cond_sel, zero, negative, ea, pc_inc, flush,
        output next_pc, taken, stack_top, stack_count, stack_empty, stack_full
`ifdef LINK_STACK_ERR_EN
        , input  err_clear
        , output stack_overflow, stack_underflow
`endif
    );
endinterface

// File: rtl/link_stack_branch_unit.sv
// Next-PC selector backed by a DEPTH-entry circular return-address stack.
// Optional sticky overflow/underflow flags when LINK_STACK_ERR_EN is defined.
module link_stack_branch_unit #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic                    clock,
    input logic                    resetn,
    link_stack_branch_unit_if.slave bus
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned SPW = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_LAST  = SPW'(DEPTH - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

    localparam logic [2:0] OP_BR    = 3'b001;
    localparam logic [2:0] OP_BRC   = 3'b010;
    localparam logic [2:0] OP_CALL  = 3'b011;
    localparam logic [2:0] OP_RET   = 3'b100;
    localparam logic [2:0] OP_CALLC = 3'b101;

    logic [AW-1:0]  entry [DEPTH];
    logic [SPW-1:0] sp;
    logic [CW-1:0]  count;

    logic           cond;
    logic           empty;
    logic           full;
    logic [AW-1:0]  top;
    logic [SPW-1:0] sp_inc;
    logic [SPW-1:0] sp_dec;
    logic [SPW-1:0] push_sp;
    logic           push;
    logic           pop;
    logic [AW-1:0]  next_pc;
    logic           taken;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign top     = empty ? '0 : entry[sp];
    assign sp_inc  = (sp == SP_LAST) ? '0 : sp + SPW'(1);
    assign sp_dec  = (sp == '0) ? SP_LAST : sp - SPW'(1);
    // The first push into an empty stack lands at the current pointer.
    assign push_sp = empty ? sp : sp_inc;

    // Condition select, next-PC mux and push/pop decode.
    always_comb begin
        cond    = 1'b0;
        next_pc = bus.pc_inc;
        taken   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        case (bus.cond_sel)
            2'b00:   cond = bus.zero;
            2'b01:   cond = bus.negative;
            2'b10:   cond = ~bus.zero;
            default: cond = ~bus.negative;
        endcase
        if (bus.op_valid) begin
            case (bus.branch_op)
                OP_BR: begin
                    next_pc = bus.ea;
                    taken   = 1'b1;
                end
                OP_BRC: begin
                    if (cond) begin
                        next_pc = bus.ea;
                        taken   = 1'b1;
                    end
                end
                OP_CALL: begin
                    next_pc = bus.ea;
                    taken   = 1'b1;
                    push    = 1'b1;
                end
                OP_CALLC: begin
                    if (cond) begin
                        next_pc = bus.ea;
                        taken   = 1'b1;
                        push    = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty) begin
                        next_pc = top;
                        taken   = 1'b1;
                        pop     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stack state; flush overrides any push or pop in the same cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sp    <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) entry[i] <= '0;
        end else if (bus.flush) begin
            sp    <= '0;
            count <= '0;
        end else if (push) begin
            sp             <= push_sp;
            entry[push_sp] <= bus.pc_inc;
            if (!full) count <= count + CW'(1);
        end else if (pop) begin
            count <= count - CW'(1);
            if (count > CW'(1)) sp <= sp_dec;
        end
    end

    assign bus.next_pc     = next_pc;
    assign bus.taken       = taken;
    assign bus.stack_top   = top;
    assign bus.stack_count = count;
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;

`ifdef LINK_STACK_ERR_EN
    logic overflow_q;
    logic underflow_q;
    logic overflow_set;
    logic underflow_set;

    assign overflow_set  = push && full && !bus.flush;
    assign underflow_set = bus.op_valid && (bus.branch_op == OP_RET) && empty && !bus.flush;

    // Sticky error flags; a set event beats a simultaneous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (overflow_set)       overflow_q  <= 1'b1;
            else if (bus.err_clear) overflow_q  <= 1'b0;
            if (underflow_set)      underflow_q <= 1'b1;
            else if (bus.err_clear) underflow_q <= 1'b0;
        end
    end

    assign bus.stack_overflow  = overflow_q;
    assign bus.stack_underflow = underflow_q;
`endif
endmodule

// File: doc/link_stack_branch_unit.md
Name: link_stack_branch_unit

Overview:
Parametrised successor to the single-entry link register. Selects the next PC for sequential, unconditional, conditional, call and return flows. Backs calls and returns with a DEPTH-entry circular return-address stack, so subroutine calls can nest. Sits between the PC incrementer and the PC register; next_pc feeds the PC register input.

Parameters:
AW, 8, address/PC width in bits.
DEPTH, 4, number of return-address entries; any value >= 2.
CW, $clog2(DEPTH+1), width of stack_count; derived, do not override.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
resetn  in  1  asynchronous, active-low reset.
op_valid  in  1  qualifies branch_op; when low, stack state holds and next_pc = pc_inc.
branch_op  in  3  000 SEQ, 001 BR, 010 BR.C, 011 CALL, 100 RET, 101 CALL.C; 110/111 decode as SEQ.
cond_sel  in  2  condition source: 00 zero, 01 negative, 10 !zero, 11 !negative.
zero  in  1  ALU zero flag.
negative  in  1  ALU negative flag.
ea  in  AW  effective branch target.
pc_inc  in  AW  PC+1, the sequential next address and the return address.
flush  in  1  synchronous stack clear.
next_pc  out  AW  selected next PC; combinational.
taken  out  1  high when next_pc != pc_inc by selection, i.e. a branch/call/return is taken; combinational.
stack_top  out  AW  entry at the stack pointer; 0 when the stack is empty.
stack_count  out  CW  number of valid entries, 0..DEPTH.
stack_empty  out  1  stack_count == 0.
stack_full  out  1  stack_count == DEPTH.

Behaviour:
- Reset (resetn low, asynchronous): all entries 0, sp = 0, stack_count = 0. Outputs: stack_top = 0, stack_empty = 1, stack_full = 0. Reset mid-operation discards every entry immediately.
- Condition: cond = mux(cond_sel) of zero/negative, evaluated combinationally in the same cycle.
- next_pc / taken (combinational, zero latency):
  - SEQ: pc_inc, taken = 0.
  - BR / CALL: ea, taken = 1.
  - BR.C / CALL.C: ea if cond is true, else pc_inc; taken = cond.
  - RET: stack_top if the stack is not empty, else pc_inc with taken = 0.
- Stack update on the rising clock edge, only when op_valid = 1 and flush = 0:
  - Push (CALL, or CALL.C with cond = 1): sp <= (sp+1) mod DEPTH when count > 0, else sp stays; entry[new sp] <= pc_inc; count <= min(count+1, DEPTH).
  - Full push: overwrites the oldest entry (circular wrap). Count stays DEPTH.
  - Pop (RET with count > 0): count <= count-1; sp <= (sp-1) mod DEPTH when count > 1. The popped entry is not cleared.
  - RET on an empty stack: no state change.
  - Pushed value is visible on stack_top from the cycle after the edge.
- flush = 1: count <= 0, sp <= 0 on the next edge. Overrides any op in the same cycle. next_pc is still computed from pre-flush state that cycle.
- op_valid = 0: next_pc = pc_inc, taken = 0, no state change.
- Pointer arithmetic is mod DEPTH for any DEPTH; wrap from DEPTH-1 to 0 and from 0 to DEPTH-1.

Optional Feature:
Macro LINK_STACK_ERR_EN.
- Defined: adds ports stack_overflow out 1, stack_underflow out 1, err_clear in 1.
  - stack_overflow is set on a push while full; stack_underflow is set on a RET while empty.
  - Both flags are sticky, reset to 0, and cleared synchronously by err_clear.
  - A set event in the same cycle as err_clear wins (the flag stays 1).
  - Stack behaviour is unchanged.
- Undefined: no such ports; overflow wraps silently and underflow returns pc_inc.

Test Plan:
- Reset, then SEQ with pc_inc = 0x11, ea = 0x40 -> next_pc = 0x11, taken = 0, stack_empty = 1.
- CALL with ea = 0x40, pc_inc = 0x11; then RET with pc_inc = 0x42 -> CALL next_pc = 0x40; RET next_pc = 0x11, taken = 1; count goes 1 then 0.
- BR.C with cond_sel = 10, zero = 0 -> next_pc = ea; with zero = 1 -> next_pc = pc_inc, taken = 0. CALL.C with the condition false -> count unchanged.
- DEPTH = 4: five CALLs pushing 0x01..0x05, then four RETs -> return 0x05, 0x04, 0x03, 0x02; fifth RET -> pc_inc, taken = 0. With LINK_STACK_ERR_EN: overflow = 1 after the fifth CALL, underflow = 1 after the fifth RET.
- Push 0x21, 0x22; assert flush together with a CALL -> count = 0 and stack_top = 0 after the edge. A following RET -> pc_inc.
- Push 0x33; drop resetn low between clock edges -> count = 0 immediately and stack_empty = 1 before the next edge.
